// File: rtl/fu_cla_pipe.sv
// fu_cla_pipe: pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// 4-bit lookahead groups, GRP_PER_STG groups per stage, registered stage carry,
// operand skew and result deskew; one beat per cycle, latency STAGES.
// Ports: clk, rst (sync, active-high); in_valid/in_ready, din1, din2, carry_in, sub;
//        out_valid/out_ready, dout, carry_out, overflow, zero, negative.
// Option: define FU_CLA_SAT_EN to add the saturate input (signed clamp on overflow).
module fu_cla_pipe #(
  parameter int WIDTH       = 32,
  parameter int GRP_PER_STG = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
`ifdef FU_CLA_SAT_EN
  ,
  input  logic             saturate
`endif
);

  localparam int SW     = 4 * GRP_PER_STG;
  localparam int STAGES = WIDTH / SW;
  localparam int L      = STAGES - 1;

  // Returns {carry out, carry into bit 3, sum[3:0]}.
  function automatic logic [5:0] cla4(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       ci
  );
    logic [3:0] g, p;
    logic [4:0] c;
    g    = a & b;
    p    = a | b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], c[3], a ^ b ^ c[3:0]};
  endfunction

  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
  logic [STAGES-1:0]            c_q, c_d, v_q, v_d, s_q, s_d;
  logic                         co_q, co_d, ov_q, ov_d;
  logic                         z_q, z_d, n_q, n_d;

  // Index k is the input of stage k; index 0 is the live operand beat.
  logic [STAGES:0][WIDTH-1:0]   a_in, b_in, r_in;
  logic [STAGES:0]              c_in, v_in, s_in;
  logic                         sat_w;
  logic                         adv;

`ifdef FU_CLA_SAT_EN
  assign sat_w = saturate;
`else
  assign sat_w = 1'b0;
`endif

  assign a_in = {a_q, din1};
  assign b_in = {b_q, (sub ? ~din2 : din2)};
  assign r_in = {r_q, {WIDTH{1'b0}}};
  assign c_in = {c_q, carry_in ^ sub};
  assign v_in = {v_q, in_valid};
  assign s_in = {s_q, sat_w};

  // Whole pipe advances together; no path from in_valid.
  assign adv      = ~v_q[L] | out_ready;
  assign in_ready = adv;

  always_comb begin
    logic [WIDTH-1:0] rs;
    logic [5:0]       gr;
    logic             c, c3;
    int               base;
    a_d  = a_in[STAGES-1:0];
    b_d  = b_in[STAGES-1:0];
    v_d  = v_in[STAGES-1:0];
    s_d  = s_in[STAGES-1:0];
    r_d  = '0;
    c_d  = '0;
    rs   = '0;
    gr   = '0;
    c    = 1'b0;
    c3   = 1'b0;
    base = 0;
    for (int k = 0; k < STAGES; k++) begin
      c  = c_in[k];
      rs = r_in[k];
      for (int g = 0; g < GRP_PER_STG; g++) begin
        base         = k * SW + 4 * g;
        gr           = cla4(a_in[k][base +: 4], b_in[k][base +: 4], c);
        rs[base +: 4] = gr[3:0];
        c3           = gr[4];
        c            = gr[5];
      end
      r_d[k] = rs;
      c_d[k] = c;
    end
    // c/c3 now hold the final stage's MSB group carries.
    co_d = c;
    ov_d = c ^ c3;
`ifdef FU_CLA_SAT_EN
    // On overflow both operands share a sign, which is the true result's sign.
    if (s_in[L] && ov_d) begin
      r_d[L] = a_in[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    z_d = ~|r_d[L];
    n_d = r_d[L][WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      r_q  <= '0;
      c_q  <= '0;
      v_q  <= '0;
      s_q  <= '0;
      co_q <= 1'b0;
      ov_q <= 1'b0;
      z_q  <= 1'b0;
      n_q  <= 1'b0;
    end else if (adv) begin
      a_q  <= a_d;
      b_q  <= b_d;
      r_q  <= r_d;
      c_q  <= c_d;
      v_q  <= v_d;
      s_q  <= s_d;
      co_q <= co_d;
      ov_q <= ov_d;
      z_q  <= z_d;
      n_q  <= n_d;
    end
  end

  assign out_valid = v_q[L];
  assign dout      = r_q[L];
  assign carry_out = co_q;
  assign overflow  = ov_q;
  assign zero      = z_q;
  assign negative  = n_q;

  // Last-stage operand copies and already-consumed skew bits are never read.
  logic unused_ok;
  assign unused_ok = ^{a_in, b_in, c_in, s_in};

endmodule
